// File: rtl/pipe_reg_rn.sv
// pipe_reg_rn: DEPTH-stage elastic pipeline register.
// Valid/ready handshake, sync flush, programmable reset value.
module pipe_reg_rn #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] rst_data,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0]            valid_q;
  logic [DEPTH-1:0]            valid_d;
  logic [DEPTH-1:0]            go;
  logic [DEPTH-1:0][WIDTH-1:0] data_q;
  logic [CW-1:0]               count_d;
  logic                        acc;

  // stage movement resolved from the output side backwards
  always_comb begin
    logic g;
    go = '0;
    g = valid_q[DEPTH-1] & out_ready;
    go[DEPTH-1] = g;
    for (int i = DEPTH-2; i >= 0; i--) begin
      g = valid_q[i] & (~valid_q[i+1] | g);
      go[i] = g;
    end
  end

  // flush blocks upstream; out_ready reaches in_ready combinationally
  always_comb begin
    in_ready = (~valid_q[0] | go[0]) & ~flush;
    acc      = in_valid & in_ready;
  end

  // next valid vector and its population count
  always_comb begin
    valid_d = '0;
    count_d = '0;
    if (!flush) begin
      valid_d[0] = acc | (valid_q[0] & ~go[0]);
      for (int i = 1; i < DEPTH; i++)
        valid_d[i] = go[i-1] | (valid_q[i] & ~go[i]);
    end
    for (int i = 0; i < DEPTH; i++)
      count_d = count_d + CW'(valid_d[i]);
  end

  // stage registers; drained stages keep stale data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      count   <= '0;
      for (int i = 0; i < DEPTH; i++)
        data_q[i] <= rst_data;
    end else begin
      valid_q <= valid_d;
      count   <= count_d;
      if (flush) begin
        for (int i = 0; i < DEPTH; i++)
          data_q[i] <= rst_data;
      end else begin
        if (acc)
          data_q[0] <= in_data;
        for (int i = 1; i < DEPTH; i++)
          if (go[i-1])
            data_q[i] <= data_q[i-1];
      end
    end
  end

  // last stage drives the outputs
  always_comb begin
    out_valid = valid_q[DEPTH-1];
    out_data  = data_q[DEPTH-1];
  end

endmodule
